// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - command-driven up-counter with one-shot/autoreload terminal count
module counter_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_autoreload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [7:0]       wrap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_START   = 2'b00;
  localparam logic [1:0] OP_STOP    = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;
  localparam logic [1:0] OP_RESTART = 2'b11;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             r_auto;
  logic             r_done;
  logic [7:0]       r_wrap;

  logic w_accept;
  logic w_terminal;
  logic w_run_override;

  assign cmd_ready      = !reset && (r_state != S_DONE);
  assign w_accept       = cmd_valid && cmd_ready;
  assign w_terminal     = (r_count == r_limit);
  // START while running is ignored, so only the other opcodes preempt counting
  assign w_run_override = w_accept && (cmd_op != OP_START);

  assign count    = r_count;
  assign done     = r_done;
  assign wrap_cnt = r_wrap;
  assign busy     = (r_state == S_RUN) || (r_state == S_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_limit <= '1;
      r_auto  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept) begin
            case (cmd_op)
              OP_START: begin
                r_state <= S_RUN;
                if (r_state == S_IDLE) begin
                  r_limit <= cmd_limit;
                  r_auto  <= cmd_autoreload;
                  r_count <= '0;
                end
              end
              OP_STOP: ;
              OP_CLEAR: begin
                r_state <= S_IDLE;
                r_count <= '0;
                r_wrap  <= 8'd0;
              end
              OP_RESTART: begin
                r_state <= S_RUN;
                r_limit <= cmd_limit;
                r_auto  <= cmd_autoreload;
                r_count <= '0;
                r_wrap  <= 8'd0;
              end
            endcase
          end
        end
        S_RUN: begin
          if (w_run_override) begin
            case (cmd_op)
              OP_STOP:  r_state <= S_HOLD;
              OP_CLEAR: begin
                r_state <= S_IDLE;
                r_count <= '0;
                r_wrap  <= 8'd0;
              end
              default: begin
                r_state <= S_RUN;
                r_limit <= cmd_limit;
                r_auto  <= cmd_autoreload;
                r_count <= '0;
                r_wrap  <= 8'd0;
              end
            endcase
          end else if (w_terminal) begin
            r_done <= 1'b1;
            if (r_auto) begin
              r_count <= '0;
              if (r_wrap != 8'hFF) r_wrap <= r_wrap + 8'd1;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_count <= r_count + WIDTH'(1);
          end
        end
        S_DONE: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - scoreboard bench for counter_ctrl against a cycle model
module tb_counter_ctrl;

  localparam logic [1:0] START = 2'b00, STOP = 2'b01, CLEAR = 2'b10, RESTART = 2'b11;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_limit;
  logic       cmd_autoreload;
  logic [2:0] count;
  logic       busy;
  logic       done;
  logic [7:0] wrap_cnt;

  typedef struct {
    logic [2:0] count;
    logic       busy;
    logic       done;
    logic [7:0] wrap;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  int       m_state = M_IDLE;
  bit [2:0] m_count = 0;
  bit [2:0] m_limit = 3'd7;
  bit       m_auto  = 0;
  bit       m_done  = 0;
  bit [7:0] m_wrap  = 0;

  counter_ctrl #(.WIDTH(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_limit      (cmd_limit),
    .cmd_autoreload (cmd_autoreload),
    .count          (count),
    .busy           (busy),
    .done           (done),
    .wrap_cnt       (wrap_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit v, input bit [1:0] op, input bit [2:0] lim,
                            input bit au, input bit rst);
    bit acc;
    acc    = v && !rst && (m_state != M_DONE);
    m_done = 0;
    if (rst) begin
      m_state = M_IDLE; m_count = 0; m_wrap = 0; m_limit = 3'd7; m_auto = 0;
    end else if (m_state == M_DONE) begin
      m_state = M_IDLE;
    end else if (acc && op == RESTART) begin
      m_limit = lim; m_auto = au; m_count = 0; m_wrap = 0; m_state = M_RUN;
    end else if (acc && op == CLEAR) begin
      m_count = 0; m_wrap = 0; m_state = M_IDLE;
    end else if (acc && op == START && m_state == M_IDLE) begin
      m_limit = lim; m_auto = au; m_count = 0; m_state = M_RUN;
    end else if (acc && op == START && m_state == M_HOLD) begin
      m_state = M_RUN;
    end else if (acc && op == STOP && m_state == M_RUN) begin
      m_state = M_HOLD;
    end else if (m_state == M_RUN) begin
      if (m_count == m_limit) begin
        m_done = 1;
        if (m_auto) begin
          m_count = 0;
          if (m_wrap != 8'd255) m_wrap = m_wrap + 8'd1;
        end else begin
          m_state = M_DONE;
        end
      end else begin
        m_count = m_count + 3'd1;
      end
    end
  endtask

  task automatic step(input bit v, input bit [1:0] op, input bit [2:0] lim,
                      input bit au, input bit rst);
    exp_t e;
    @(negedge clk);
    cmd_valid = v; cmd_op = op; cmd_limit = lim; cmd_autoreload = au; reset = rst;
    #1;
    check("cmd_ready", cmd_ready, (!rst && m_state != M_DONE) ? 1 : 0);
    model_step(v, op, lim, au, rst);
    e.count = m_count;
    e.busy  = (m_state == M_RUN || m_state == M_HOLD);
    e.done  = m_done;
    e.wrap  = m_wrap;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("count", count, e.count);
      check("busy", busy, e.busy);
      check("done", done, e.done);
      check("wrap_cnt", wrap_cnt, e.wrap);
    end
    if (done === 1'b1) n_done++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
  endtask

  initial begin
    cmd_valid = 0; cmd_op = 0; cmd_limit = 0; cmd_autoreload = 0; reset = 1;

    step(0, START, 0, 0, 1);
    step(1, START, 3, 1, 1);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);

    // one-shot, limit 5
    n_done = 0;
    step(1, START, 5, 0, 0);
    idle(7);
    check("os_done_pulses", n_done, 1);
    check("os_final_count", count, 5);
    check("os_final_wrap", wrap_cnt, 0);

    // autoreload, limit 2
    step(1, RESTART, 2, 1, 0);
    n_done = 0;
    idle(9);
    check("ar_done_pulses", n_done, 3);
    check("ar_wrap", wrap_cnt, 3);
    step(1, CLEAR, 0, 0, 0);

    // pause and resume
    step(1, START, 7, 0, 0);
    idle(3);
    step(1, STOP, 0, 0, 0);
    idle(4);
    check("hold_count", count, 3);
    check("hold_busy", busy, 1);
    n_done = 0;
    step(1, START, 0, 0, 0);
    idle(6);
    check("resume_done_pulses", n_done, 1);
    check("resume_final_count", count, 7);

    // STOP colliding with the terminal cycle
    step(1, START, 4, 0, 0);
    idle(4);
    step(1, STOP, 0, 0, 0);
    check("coll_count", count, 4);
    check("coll_done", done, 0);
    check("coll_busy", busy, 1);
    step(1, CLEAR, 0, 0, 0);
    check("coll_clear_count", count, 0);

    // reset mid-run
    step(1, START, 7, 0, 0);
    idle(2);
    step(0, START, 0, 0, 1);
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    step(1, START, 7, 0, 1);
    step(1, STOP, 0, 0, 0);

    // wrap saturation, then a command during DONE
    step(1, RESTART, 0, 1, 0);
    idle(300);
    check("sat_wrap", wrap_cnt, 255);
    step(1, CLEAR, 0, 0, 0);
    step(1, START, 0, 0, 0);
    idle(1);
    check("l0_done", done, 1);
    step(1, RESTART, 3, 1, 0);
    check("done_cmd_ignored_busy", busy, 0);

    // random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
